// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter sharing one registered leaf_interface output among NUM_REQ streams.
// Optional LEAF_ARB_TAG_EN adds a registered src_id output naming the producer of dout.
module leaf_out_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned BURST_WORDS  = 4,
  parameter int unsigned IDX_W        = 2
) (
  input  logic                            clk_user,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
  input  logic [NUM_REQ-1:0]              vld_req,
  output logic [NUM_REQ-1:0]              ack_req,
  output logic [PAYLOAD_BITS-1:0]         dout,
  output logic                            vld_out,
  input  logic                            ack_out
`ifdef LEAF_ARB_TAG_EN
  ,
  output logic [IDX_W-1:0]                src_id
`endif
);

  localparam int unsigned CNT_W = (BURST_WORDS < 2) ? 1 : $clog2(BURST_WORDS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          grant_idx;
  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          rr_next;
  logic [CNT_W-1:0]          burst_cnt;
  logic [IDX_W-1:0]          pick_idx;
  logic [IDX_W-1:0]          pick_cand;
  logic                      pick_found;
  logic [PAYLOAD_BITS-1:0]   grant_word;
  logic                      grant_vld;
  logic                      free;
  logic                      xfer;
  logic                      leave;

  assign free      = !vld_out || ack_out;
  assign grant_vld = vld_req[grant_idx];
  assign rr_next   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pick_cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && vld_req[pick_cand]) begin
        pick_found = 1'b1;
        pick_idx   = pick_cand;
      end
    end
  end

  always_comb begin
    grant_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) grant_word = din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  // State register.
  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: release the grant on a finished burst or when the grantee goes idle.
  always_comb begin
    state_d = state_q;
    leave   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) state_d = GRANT;
      end
      GRANT: begin
        if (!grant_vld || (xfer && burst_cnt == CNT_W'(BURST_WORDS - 1))) begin
          state_d = IDLE;
          leave   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Acks are combinational so a freeing downstream ack can be used in the same cycle.
  always_comb begin
    ack_req = '0;
    xfer    = 1'b0;
    if (state_q == GRANT && grant_vld && free) begin
      ack_req[grant_idx] = 1'b1;
      xfer               = 1'b1;
    end
  end

  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) begin
      grant_idx <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      if (state_q == IDLE && pick_found) begin
        grant_idx <= pick_idx;
        burst_cnt <= '0;
      end else if (xfer) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
      if (leave) rr_ptr <= rr_next;
    end
  end

  // Output stage holds its word until the leaf interface accepts it.
  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) begin
      dout    <= '0;
      vld_out <= 1'b0;
    end else if (xfer) begin
      dout    <= grant_word;
      vld_out <= 1'b1;
    end else if (ack_out) begin
      vld_out <= 1'b0;
    end
  end

`ifdef LEAF_ARB_TAG_EN
  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset)    src_id <= '0;
    else if (xfer) src_id <= grant_idx;
  end
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: cycle model of the grant rules plus an in-order word scoreboard.
module tb_leaf_out_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned P  = 32;
  localparam int unsigned B  = 4;
  localparam int unsigned IW = 2;

  logic           clk_user = 1'b0;
  logic           reset    = 1'b0;
  logic [N*P-1:0] din_req  = '0;
  logic [N-1:0]   vld_req  = '0;
  logic [N-1:0]   ack_req;
  logic [P-1:0]   dout;
  logic           vld_out;
  logic           ack_out  = 1'b0;
`ifdef LEAF_ARB_TAG_EN
  logic [IW-1:0]  src_id;
`endif

  always #5 clk_user = ~clk_user;

  leaf_out_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(P), .BURST_WORDS(B), .IDX_W(IW)) dut (
    .clk_user (clk_user),
    .reset    (reset),
    .din_req  (din_req),
    .vld_req  (vld_req),
    .ack_req  (ack_req),
    .dout     (dout),
    .vld_out  (vld_out),
    .ack_out  (ack_out)
`ifdef LEAF_ARB_TAG_EN
    ,
    .src_id   (src_id)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: current grantee (-1 = none), words granted this burst, rotation pointer, output slot.
  int          m_owner = -1;
  int          m_cnt   = 0;
  int          m_ptr   = 0;
  logic        m_vld   = 1'b0;
  logic [31:0] m_dout  = '0;
  int          m_src   = 0;

  logic [31:0] base [N];
  int unsigned seq  [N];
  logic [31:0] sb      [$];
  logic [31:0] order_q [$];

  logic [N-1:0] obs_ack;
  logic         obs_vld;
  logic [31:0]  obs_dout;

  int exp_b_vld [11] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};

  function automatic logic [31:0] src_word(input int i);
    return base[i] + 32'(seq[i]);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare after settling, then advance the model.
  task automatic step(input logic rst_v, input logic [N-1:0] v, input logic a);
    logic [N-1:0] exp_ack;
    logic         acc;
    int           pick;
    @(negedge clk_user);
    reset   = rst_v;
    vld_req = v;
    ack_out = a;
    for (int i = 0; i < N; i++) din_req[i*P +: P] = src_word(i);
    #1;
    obs_ack  = ack_req;
    obs_vld  = vld_out;
    obs_dout = dout;
    if (!rst_v) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_vld = 1'b0; m_dout = '0; m_src = 0;
      sb.delete();
    end
    exp_ack = '0;
    if (rst_v && m_owner >= 0 && v[2'(m_owner)] && (!m_vld || a)) exp_ack[2'(m_owner)] = 1'b1;
    chk("ack_req", 32'(ack_req), 32'(exp_ack));
    chk("vld_out", 32'(vld_out), 32'(m_vld));
    if (m_vld || !rst_v) chk("dout", dout, m_dout);
`ifdef LEAF_ARB_TAG_EN
    if (m_vld || !rst_v) chk("src_id", 32'(src_id), 32'(m_src));
`endif
    if (rst_v && vld_out && a) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow got=%h exp=none at %0t", dout, $time);
      end else begin
        chk("sb_word", dout, sb.pop_front());
      end
      order_q.push_back(dout);
    end
    if (rst_v) begin
      acc = (exp_ack != '0);
      if (acc) begin
        m_vld = 1'b1; m_dout = src_word(m_owner); m_src = m_owner; m_cnt++;
      end else if (a) begin
        m_vld = 1'b0;
      end
      if (m_owner < 0) begin
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && v[2'((m_ptr + k) % N)]) pick = (m_ptr + k) % N;
        if (pick >= 0) begin m_owner = pick; m_cnt = 0; end
      end else if (!v[2'(m_owner)] || (acc && m_cnt == B)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
      // Sources advance on the DUT's actual handshake; the scoreboard remembers what left.
      for (int i = 0; i < N; i++) begin
        if (ack_req[i] && v[i]) begin
          sb.push_back(src_word(i));
          seq[i]++;
        end
      end
    end
  endtask

  task automatic reset_tb();
    for (int i = 0; i < N; i++) begin
      seq[i]  = 0;
      base[i] = {4'(i), 28'h0};
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      seq[i]  = 0;
      base[i] = {4'(i), 28'h0};
    end

    // Reset held with every requester valid, then release.
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 4'hF, 1'b1);
      chk("rst_vld", 32'(obs_vld), 32'd0);
      chk("rst_ack", 32'(obs_ack), 32'd0);
    end
    step(1'b1, 4'hF, 1'b1);
    chk("rel_ack_idle", 32'(obs_ack), 32'd0);
    step(1'b1, 4'hF, 1'b1);
    chk("rel_ack_req0", 32'(obs_ack), 32'b0001);

    // Only req2 valid: two bursts of four with one bubble between them.
    reset_tb();
    base[2] = 32'hA0;
    for (int k = 0; k < 11; k++) begin
      step(1'b1, (seq[2] < 8) ? 4'b0100 : 4'b0000, 1'b1);
      chk("b_vld", 32'(obs_vld), 32'(exp_b_vld[k]));
      if (k >= 2 && k <= 5)  chk("b_dout", obs_dout, 32'hA0 + 32'(k - 2));
      if (k >= 7 && k <= 10) chk("b_dout", obs_dout, 32'hA4 + 32'(k - 7));
    end

    // All requesters busy: four words per grant, rotating 0,1,2,3,0.
    reset_tb();
    order_q.delete();
    for (int k = 0; k < 40; k++) step(1'b1, 4'hF, 1'b1);
    chk("c_count", 32'(order_q.size() >= 20), 32'd1);
    for (int k = 0; k < 20 && k < order_q.size(); k++)
      chk("c_order", 32'(order_q[k][31:28]), 32'((k / 4) % 4));

    // Downstream stall: output word held, no acks, nothing lost on resume.
    reset_tb();
    base[0] = 32'h12345678;
    step(1'b1, 4'b0001, 1'b1);
    step(1'b1, 4'b0001, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b0001, 1'b0);
      chk("d_dout", obs_dout, 32'h12345678);
      chk("d_ack", 32'(obs_ack), 32'd0);
    end
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0001, 1'b1);

    // req1 drops out after two words; req3 is granted next.
    reset_tb();
    step(1'b1, 4'b1010, 1'b1); chk("e_idle", 32'(obs_ack), 32'd0);
    step(1'b1, 4'b1010, 1'b1); chk("e_w0", 32'(obs_ack), 32'b0010);
    step(1'b1, 4'b1010, 1'b1); chk("e_w1", 32'(obs_ack), 32'b0010);
    step(1'b1, 4'b1000, 1'b1); chk("e_drop", 32'(obs_ack), 32'd0);
    step(1'b1, 4'b1000, 1'b1); chk("e_idle2", 32'(obs_ack), 32'd0);
    step(1'b1, 4'b1000, 1'b1); chk("e_req3", 32'(obs_ack), 32'b1000);

    // Asynchronous reset in the middle of a req2 burst.
    reset_tb();
    step(1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    chk("f_pre_vld", 32'(obs_vld), 32'd1);
    step(1'b0, 4'b0100, 1'b1);
    chk("f_vld", 32'(obs_vld), 32'd0);
    chk("f_ack", 32'(obs_ack), 32'd0);
    step(1'b1, 4'hF, 1'b1); chk("f_idle", 32'(obs_ack), 32'd0);
    step(1'b1, 4'hF, 1'b1); chk("f_req0", 32'(obs_ack), 32'b0001);

    // Random traffic and back-pressure with one reset pulse in the middle.
    reset_tb();
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(9) < 7);
      step((k == 1500) ? 1'b0 : 1'b1, v, ($urandom_range(3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
